// File: rtl/gfx_pkg.sv
// gfx_pkg: types shared by the wireframe triangle path.
//   CORDW         - signed screen-coordinate width, shared with LineDrawing
//   vertex_t      - one signed (x, y) point
//   triangle_t    - three vertices v0, v1, v2 (one FIFO command entry)
//   sched_state_t - edge scheduler FSM states
//   edge_start / edge_end - vertex selection for edge index 0..2
package gfx_pkg;

    localparam int CORDW = 16;

    typedef struct packed {
        logic signed [CORDW-1:0] x;
        logic signed [CORDW-1:0] y;
    } vertex_t;

    typedef struct packed {
        vertex_t v0;
        vertex_t v1;
        vertex_t v2;
    } triangle_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT
    } sched_state_t;

    // Edges are walked v0->v1, v1->v2, v2->v0 so the outline closes.
    function automatic vertex_t edge_start(input triangle_t t, input logic [1:0] e);
        case (e)
            2'd0:    return t.v0;
            2'd1:    return t.v1;
            default: return t.v2;
        endcase
    endfunction

    function automatic vertex_t edge_end(input triangle_t t, input logic [1:0] e);
        case (e)
            2'd0:    return t.v1;
            2'd1:    return t.v2;
            default: return t.v0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: generic synchronous FIFO for command queues.
//   clock, reset  - system clock, synchronous active-high reset (empties queue)
//   push, wdata   - write request and data; ignored while full
//   pop           - consume the head entry; ignored while empty
//   rdata         - head entry (first-word fall-through)
//   full, empty   - occupancy flags derived from registered pointers only
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells full from empty when the indices match.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/triangle_edge_scheduler.sv
// triangle_edge_scheduler: queues wireframe triangle commands and feeds their
// three edges, one at a time, to the shared LineDrawing datapath.
//   clock, reset            - system clock, synchronous active-high reset
//   io_inValid/io_inReady   - triangle command handshake (ready = queue not full)
//   io_x0..io_y2            - signed vertices, captured on handshake
//   io_lineStart            - one-cycle start pulse to LineDrawing
//   io_xs/io_ys/io_xe/io_ye - registered edge endpoints, held while drawing
//   io_lineDone             - LineDrawing completion pulse
//   io_busy                 - commands queued or an edge sequence in progress
//   io_triCount             - triangles completed since reset (wraps)
module triangle_edge_scheduler #(
    parameter int CORDW      = gfx_pkg::CORDW,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_inValid,
    output logic                    io_inReady,
    input  logic signed [CORDW-1:0] io_x0,
    input  logic signed [CORDW-1:0] io_y0,
    input  logic signed [CORDW-1:0] io_x1,
    input  logic signed [CORDW-1:0] io_y1,
    input  logic signed [CORDW-1:0] io_x2,
    input  logic signed [CORDW-1:0] io_y2,
    output logic                    io_lineStart,
    output logic signed [CORDW-1:0] io_xs,
    output logic signed [CORDW-1:0] io_ys,
    output logic signed [CORDW-1:0] io_xe,
    output logic signed [CORDW-1:0] io_ye,
    input  logic                    io_lineDone,
    output logic                    io_busy,
    output logic [15:0]             io_triCount
);

    gfx_pkg::triangle_t    fifo_wdata;
    gfx_pkg::triangle_t    fifo_rdata;
    gfx_pkg::triangle_t    tri_q;
    gfx_pkg::triangle_t    edge_src;
    gfx_pkg::vertex_t      vs_nxt;
    gfx_pkg::vertex_t      ve_nxt;
    gfx_pkg::sched_state_t state;
    gfx_pkg::sched_state_t state_nxt;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [1:0]  edge_idx;
    logic [1:0]  edge_nxt;
    logic        tri_done;
    logic [15:0] tri_cnt;
    logic signed [CORDW-1:0] xs_q;
    logic signed [CORDW-1:0] ys_q;
    logic signed [CORDW-1:0] xe_q;
    logic signed [CORDW-1:0] ye_q;

    always_comb begin
        fifo_wdata.v0.x = io_x0;
        fifo_wdata.v0.y = io_y0;
        fifo_wdata.v1.x = io_x1;
        fifo_wdata.v1.y = io_y1;
        fifo_wdata.v2.x = io_x2;
        fifo_wdata.v2.y = io_y2;
    end

    assign fifo_push = io_inValid && !fifo_full;

    cmd_fifo #(
        .WIDTH($bits(gfx_pkg::triangle_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .wdata(fifo_wdata),
        .pop  (fifo_pop),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        edge_nxt  = edge_idx;
        fifo_pop  = 1'b0;
        tri_done  = 1'b0;
        case (state)
            gfx_pkg::IDLE: begin
                if (!fifo_empty) state_nxt = gfx_pkg::LOAD;
            end
            gfx_pkg::LOAD: begin
                fifo_pop  = 1'b1;
                edge_nxt  = 2'd0;
                state_nxt = gfx_pkg::START;
            end
            gfx_pkg::START: begin
                // A done pulse here belongs to nothing we issued; drop it.
                state_nxt = gfx_pkg::WAIT;
            end
            gfx_pkg::WAIT: begin
                if (io_lineDone) begin
                    if (edge_idx != 2'd2) begin
                        edge_nxt  = edge_idx + 2'd1;
                        state_nxt = gfx_pkg::START;
                    end else begin
                        tri_done  = 1'b1;
                        state_nxt = fifo_empty ? gfx_pkg::IDLE : gfx_pkg::LOAD;
                    end
                end
            end
            default: state_nxt = gfx_pkg::IDLE;
        endcase
    end

    // Edge 0 is loaded in the same cycle as the pop, so its vertices come
    // straight from the FIFO head; later edges come from the held triangle.
    always_comb begin
        edge_src = (state == gfx_pkg::LOAD) ? fifo_rdata : tri_q;
        vs_nxt   = gfx_pkg::edge_start(edge_src, edge_nxt);
        ve_nxt   = gfx_pkg::edge_end(edge_src, edge_nxt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= gfx_pkg::IDLE;
            edge_idx <= 2'd0;
            tri_cnt  <= 16'd0;
            xs_q     <= '0;
            ys_q     <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
        end else begin
            state    <= state_nxt;
            edge_idx <= edge_nxt;
            if (tri_done) tri_cnt <= tri_cnt + 16'd1;
            // Endpoints only move on entry to START and stay put through WAIT.
            if (state_nxt == gfx_pkg::START) begin
                xs_q <= vs_nxt.x;
                ys_q <= vs_nxt.y;
                xe_q <= ve_nxt.x;
                ye_q <= ve_nxt.y;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_pop) tri_q <= fifo_rdata;
    end

    assign io_inReady   = !fifo_full;
    assign io_lineStart = (state == gfx_pkg::START);
    assign io_xs        = xs_q;
    assign io_ys        = ys_q;
    assign io_xe        = xe_q;
    assign io_ye        = ye_q;
    assign io_busy      = !fifo_empty || (state != gfx_pkg::IDLE);
    assign io_triCount  = tri_cnt;

endmodule
